clmul_share_ctrl: RTL and testbench
===================================

Name: clmul_share_ctrl

Overview:
- Sequencing controller and two-port round-robin arbiter for the shared multi-cycle carry-less/unsigned multiplier unit.
- Accepts 32-bit bitmanip multiply ops (CLMUL, CLMULH, CLMULR, MUL, MULHU) from two requesters over valid/ready.
- Drives the unit's start/mul/operand inputs, holds the mode stable for the whole computation, and catches the done pulse.
- Selects the 32-bit result slice from the 64-bit product and returns it on a per-requester valid/ready response channel. One operation is outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters; fixed at 2, other values unsupported.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 op valid
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  3  0=CLMUL 1=CLMULH 2=CLMULR 3=MUL 4=MULHU 5..7 reserved
- req0_rs1  in  32  operand a
- req0_rs2  in  32  operand b
- rsp0_valid  out  1  result valid for requester 0
- rsp0_ready  in  1  requester 0 takes result
- rsp0_data  out  32  result
- req1_valid, req1_ready, req1_op, req1_rs1, req1_rs2, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for requester 1
- unit_start  out  1  one-cycle start pulse to multiplier
- unit_mul  out  1  1=integer multiply, 0=carry-less
- unit_rs1  out  32  operand a to unit
- unit_rs2  out  32  operand b to unit
- unit_rd  in  64  unit product
- unit_busy  in  1  unit busy (monitor only)
- unit_done  in  1  one-cycle done pulse, 5 cycles after start

Behaviour:
- Reset is synchronous and active-high; the clock is clock. The unit shares the same reset.
- Reset values: state IDLE, rsp*_valid=0, rsp*_data=0, unit_start=0, unit_mul=0, unit_rs1/rs2=0, RR pointer favours requester 0.
- IDLE state:
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational from valid and the pointer; at most one ready is high.
  - One valid: that requester is granted. Both valid: the requester not granted last is granted.
  - The pointer updates only on an accepted handshake.
- On accept:
  - Register op, rs1, rs2 and owner id.
  - Ops 0..4 go to START.
  - Reserved ops 5..7 go to RESP with data 0 and the unit is never started.
- START (1 cycle):
  - unit_start=1; unit_rs1/rs2 come from registers.
  - unit_mul = (op==MUL || op==MULHU).
  - Next state is WAIT.
- WAIT:
  - unit_start=0. unit_mul is held at the registered value; the unit samples it every cycle, so it must not change until done.
  - On unit_done, register the result and go to RESP.
  - unit_done seen in any state other than WAIT is ignored.
- Result slice (p = unit_rd):
  - CLMUL/MUL: p[31:0]
  - CLMULH/MULHU: p[63:32]
  - CLMULR: p[62:31]
- RESP:
  - rspOWNER_valid=1 and rsp data is stable until rspOWNER_ready. The non-owner's valid stays 0.
  - On the handshake, clear valid and go to IDLE.
  - Backpressure is unbounded, and no new request is accepted while in RESP.
- Timing: accept at cycle A -> unit_start at A+1 -> unit_done at A+6 -> rsp_valid at A+7.
  - If the response is taken at R, the earliest next accept is R+1.
  - Reserved op: rsp_valid at A+1.
- Reset mid-operation (START/WAIT/RESP): return to IDLE next cycle. The pending result is dropped, no response is produced, and the pointer returns to favour requester 0.
- Requester valid/op/operands may change while not ready; only the values present at the handshake cycle matter.

Test Plan:
- Req0 CLMUL rs1=3 rs2=3 -> unit_start at A+1 with unit_mul=0, rsp0_valid at A+7, rsp0_data=0x00000005.
- Req1 CLMULH then CLMULR, both with rs1=rs2=0x80000000 -> rsp1_data 0x40000000 then 0x80000000; unit_mul=0 throughout WAIT.
- Req0 MUL then MULHU, both with rs1=rs2=0xFFFFFFFF -> results 0x00000001 then 0xFFFFFFFE; unit_mul=1 held from START until done.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1; never two readys in one cycle; each response goes only to its owner.
- Hold rsp0_ready=0 for 20 cycles -> rsp0_valid/data stable, no req accepted; ready at cycle R -> next accept at R+1. Reserved op 6 -> data 0 at A+1, unit_start never pulses.
- Assert reset during WAIT -> next cycle IDLE, no rsp_valid ever for the aborted op; next request accepted and computes correctly.

Source files
------------

// File: rtl/clmul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clmul_share_ctrl
// Description : Two-port round-robin arbiter and sequencer for the shared
//               multi-cycle carry-less / unsigned multiplier unit. Accepts one
//               op at a time (CLMUL, CLMULH, CLMULR, MUL, MULHU), starts the
//               unit, holds its mode until done, slices the 64-bit product
//               and returns the 32-bit result to the owning requester.
// Ports       : clock, reset            - clock, synchronous active-high reset
//               reqN_valid/ready/op/rs1/rs2 - op request channel, N = 0,1
//               rspN_valid/ready/data   - result channel, N = 0,1
//               unit_start/mul/rs1/rs2  - drive to the multiplier unit
//               unit_rd/busy/done       - product, busy (unused), done pulse
// Revision    : 1.0 - initial release
// ============================================================================
module clmul_share_ctrl #(
    parameter int NUM_REQ = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        unit_start,
    output logic        unit_mul,
    output logic [31:0] unit_rs1,
    output logic [31:0] unit_rs2,
    input  logic [63:0] unit_rd,
    input  logic        unit_busy,
    input  logic        unit_done
);

    localparam int C_OWNER_W = $clog2(NUM_REQ);

    localparam logic [2:0] C_OP_CLMUL  = 3'd0;
    localparam logic [2:0] C_OP_CLMULH = 3'd1;
    localparam logic [2:0] C_OP_CLMULR = 3'd2;
    localparam logic [2:0] C_OP_MUL    = 3'd3;
    localparam logic [2:0] C_OP_MULHU  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [2:0]             r_op;
    logic [31:0]            r_rs1;
    logic [31:0]            r_rs2;
    logic [C_OWNER_W-1:0]   r_owner;
    logic [C_OWNER_W-1:0]   r_last;     // requester granted most recently
    logic                   r_mul;
    logic [31:0]            r_data;

    logic [C_OWNER_W-1:0]   w_grant;
    logic                   w_ready0;
    logic                   w_ready1;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_capture;
    logic                   w_rsp0;
    logic                   w_rsp1;
    logic [2:0]             w_acc_op;
    logic [31:0]            w_acc_rs1;
    logic [31:0]            w_acc_rs2;
    logic [31:0]            w_slice;
    logic                   w_unused_busy;

    // The unit's busy flag is informational only; sequencing relies on done.
    assign w_unused_busy = unit_busy;

    // Round-robin grant: a lone requester wins outright; on contention the
    // requester that was not granted last wins.
    always_comb begin
        w_grant = '0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end else if (req1_valid) begin
            w_grant = C_OWNER_W'(1);
        end
    end

    assign w_acc_op  = (w_grant != '0) ? req1_op  : req0_op;
    assign w_acc_rs1 = (w_grant != '0) ? req1_rs1 : req0_rs1;
    assign w_acc_rs2 = (w_grant != '0) ? req1_rs2 : req0_rs2;
    assign w_accept  = w_ready0 || w_ready1;

    // Result slice selection; CLMULR is the reversed-product view p[62:31].
    always_comb begin
        w_slice = '0;
        case (r_op)
            C_OP_CLMUL,  C_OP_MUL:   w_slice = unit_rd[31:0];
            C_OP_CLMULH, C_OP_MULHU: w_slice = unit_rd[63:32];
            C_OP_CLMULR:             w_slice = unit_rd[62:31];
            default:                 w_slice = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_rsp0       = 1'b0;
        w_rsp1       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready0 = req0_valid && (w_grant == '0);
                w_ready1 = req1_valid && (w_grant != '0);
                if (w_ready0 || w_ready1) begin
                    // Reserved ops bypass the unit entirely.
                    w_next_state = (w_acc_op > C_OP_MULHU) ? S_RESP : S_START;
                end
            end
            S_START: begin
                w_start      = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (unit_done) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp0 = (r_owner == '0);
                w_rsp1 = (r_owner != '0);
                if ((w_rsp0 && rsp0_ready) || (w_rsp1 && rsp1_ready)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_owner <= '0;
            r_last  <= C_OWNER_W'(1);   // next contention favours requester 0
            r_mul   <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= w_acc_op;
                r_rs1   <= w_acc_rs1;
                r_rs2   <= w_acc_rs2;
                r_owner <= w_grant;
                r_last  <= w_grant;
                // Mode is latched once and held for the whole computation.
                r_mul   <= (w_acc_op == C_OP_MUL) || (w_acc_op == C_OP_MULHU);
                r_data  <= '0;
            end
            if (w_capture) begin
                r_data <= w_slice;
            end
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign rsp0_valid = w_rsp0;
    assign rsp1_valid = w_rsp1;
    assign rsp0_data  = r_data;
    assign rsp1_data  = r_data;
    assign unit_start = w_start;
    assign unit_mul   = r_mul;
    assign unit_rs1   = r_rs1;
    assign unit_rs2   = r_rs2;

endmodule
`default_nettype wire

// File: tb/tb_clmul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clmul_share_ctrl
// Description : Self-checking bench for clmul_share_ctrl with a behavioural
//               multiplier-unit model and a reference result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clmul_share_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_rs1, req0_rs2, rsp0_data;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_rs1, req1_rs2, rsp1_data;
    logic        unit_start, unit_mul, unit_busy, unit_done;
    logic [31:0] unit_rs1, unit_rs2;
    logic [63:0] unit_rd;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_starts = 0;

    always #5 clock = ~clock;

    clmul_share_ctrl #(.NUM_REQ(2)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .unit_start(unit_start), .unit_mul(unit_mul),
        .unit_rs1(unit_rs1), .unit_rs2(unit_rs2),
        .unit_rd(unit_rd), .unit_busy(unit_busy), .unit_done(unit_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p = '0;
        for (int i = 0; i < 32; i++)
            if (b[i]) p = p ^ ({32'b0, a} << i);
        return p;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] c = clmul64(a, b);
        logic [63:0] m = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0:    return c[31:0];
            3'd1:    return c[63:32];
            3'd2:    return c[62:31];
            3'd3:    return m[31:0];
            3'd4:    return m[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- behavioural multiplier unit (done 5 cycles after start)
    logic [2:0]  u_cnt = '0;
    logic        u_mul = 1'b0;
    logic [31:0] u_a = '0, u_b = '0;
    logic        u_done_r = 1'b0;
    logic [63:0] u_rd = '0;
    logic        stray_done = 1'b0;
    logic [63:0] stray_rd = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (unit_start) n_starts <= n_starts + 1;
        if (reset) begin
            u_cnt    <= '0;
            u_done_r <= 1'b0;
        end else begin
            u_done_r <= 1'b0;
            if (unit_start) begin
                u_cnt <= 3'd1;
                u_mul <= unit_mul;
                u_a   <= unit_rs1;
                u_b   <= unit_rs2;
            end else if (u_cnt != 0) begin
                chk("unit_mul_held", {63'b0, unit_mul}, {63'b0, u_mul});
                if (u_cnt == 3'd4) begin
                    u_done_r <= 1'b1;
                    u_rd     <= u_mul ? ({32'b0, u_a} * {32'b0, u_b}) : clmul64(u_a, u_b);
                    u_cnt    <= '0;
                end else begin
                    u_cnt <= u_cnt + 3'd1;
                end
            end
        end
    end

    assign unit_done = u_done_r | stray_done;
    assign unit_rd   = stray_done ? stray_rd : u_rd;
    assign unit_busy = (u_cnt != 0);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble();
        req0_op  = 3'($urandom_range(0, 7)); req0_rs1 = $urandom; req0_rs2 = $urandom;
        req1_op  = 3'($urandom_range(0, 7)); req1_rs1 = $urandom; req1_rs2 = $urandom;
    endtask

    // One full transaction on one port; returns accept cycle and the cycle the
    // response was taken. hold = cycles of response backpressure.
    task automatic do_op(input int port, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, output int acc, output int rel);
        logic [31:0] exp;
        logic        got;
        int          st0, rcyc;
        logic [31:0] d0;
        exp = ref_result(op, a, b);
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_rs1 = a; req0_rs2 = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_rs1 = a; req1_rs2 = b;
        end
        got = 1'b0; acc = -1; st0 = n_starts;
        for (int w = 0; w < 50 && !got; w++) begin
            #1;
            if ((port == 0) ? req0_ready : req1_ready) begin
                got = 1'b1; acc = cyc; st0 = n_starts;
            end
            tick();
        end
        chk("accept_seen", {63'b0, got}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        scramble();
        if (op <= 3'd4) begin
            chk("start_pulse", {63'b0, unit_start}, 64'd1);
            chk("start_mul", {63'b0, unit_mul}, {63'b0, (op == 3'd3 || op == 3'd4)});
            chk("start_rs1", {32'b0, unit_rs1}, {32'b0, a});
            chk("start_rs2", {32'b0, unit_rs2}, {32'b0, b});
        end
        got = 1'b0; rcyc = -1;
        for (int w = 0; w < 50 && !got; w++) begin
            if ((port == 0) ? rsp0_valid : rsp1_valid) begin
                got = 1'b1; rcyc = cyc;
            end else begin
                tick();
            end
        end
        chk("rsp_seen", {63'b0, got}, 64'd1);
        chk("rsp_latency", 64'(rcyc - acc), (op <= 3'd4) ? 64'd7 : 64'd1);
        d0 = (port == 0) ? rsp0_data : rsp1_data;
        chk("rsp_data", {32'b0, d0}, {32'b0, exp});
        chk("rsp_other_valid", {63'b0, (port == 0) ? rsp1_valid : rsp0_valid}, 64'd0);
        chk("start_count", 64'(n_starts - st0), (op <= 3'd4) ? 64'd1 : 64'd0);
        for (int h = 0; h < hold; h++) begin
            req0_valid = 1'b1; req1_valid = 1'b1; scramble();
            #1;
            chk("hold_no_ready", {62'b0, req1_ready, req0_ready}, 64'd0);
            chk("hold_valid", {63'b0, (port == 0) ? rsp0_valid : rsp1_valid}, 64'd1);
            chk("hold_data", {32'b0, (port == 0) ? rsp0_data : rsp1_data}, {32'b0, d0});
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (hold > 0) chk("hold_no_start", 64'(n_starts - st0), (op <= 3'd4) ? 64'd1 : 64'd0);
        if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        rel = cyc;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        chk("rsp_cleared", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin : main
        int acc, rel, acc2, rel2;
        int n_done, g;
        logic exp_next;
        int q_port[$];
        logic [31:0] q_data[$];

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_op = '0; req0_rs1 = '0; req0_rs2 = '0;
        req1_op = '0; req1_rs1 = '0; req1_rs2 = '0;
        tick(); tick();
        chk("reset_rsp_valid", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
        chk("reset_rsp_data", {rsp1_data, rsp0_data}, 64'd0);
        chk("reset_unit_ctl", {62'b0, unit_start, unit_mul}, 64'd0);
        chk("reset_unit_ops", {unit_rs1, unit_rs2}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed results
        do_op(0, 3'd0, 32'd3, 32'd3, 0, acc, rel);
        do_op(1, 3'd1, 32'h80000000, 32'h80000000, 0, acc, rel);
        do_op(1, 3'd2, 32'h80000000, 32'h80000000, 0, acc, rel);
        do_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, acc, rel);
        do_op(0, 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, acc, rel);

        // Backpressure on a reserved op, then back-to-back accept
        do_op(0, 3'd6, $urandom, $urandom, 20, acc, rel);
        do_op(1, 3'd0, 32'h12345678, 32'h9ABCDEF1, 0, acc2, rel2);
        chk("accept_after_release", 64'(acc2), 64'(rel + 1));
        do_op(1, 3'd3, 32'hDEADBEEF, 32'h0BADF00D, 20, acc, rel);
        do_op(0, 3'd2, 32'hCAFEF00D, 32'h13579BDF, 0, acc2, rel2);
        chk("accept_after_release2", 64'(acc2), 64'(rel + 1));

        // A done pulse while idle must not produce a response
        stray_done = 1'b1; stray_rd = {$urandom, $urandom};
        tick();
        stray_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_done_ignored", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
            tick();
        end

        // Random single ops
        for (int i = 0; i < 8; i++)
            do_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  int'($urandom_range(0, 3)), acc, rel);

        // Contention after reset: grants alternate starting with requester 0
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_next = 1'b0; n_done = 0;
        for (int c = 0; c < 300 && n_done < 8; c++) begin
            scramble();
            #1;
            chk("one_ready", {63'b0, req0_ready & req1_ready}, 64'd0);
            if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
                chk("grant_order", 64'(g), {63'b0, exp_next});
                q_port.push_back(g);
                q_data.push_back(g ? ref_result(req1_op, req1_rs1, req1_rs2)
                                   : ref_result(req0_op, req0_rs1, req0_rs2));
                exp_next = (g == 0);
            end
            chk("rsp_both_valid", {63'b0, rsp0_valid & rsp1_valid}, 64'd0);
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_expected", 64'(q_port.size() > 0), 64'd1);
                if (q_port.size() > 0) begin
                    chk("rsp_owner", {63'b0, rsp1_valid}, 64'(q_port[0]));
                    chk("rsp_alt_data", {32'b0, rsp1_valid ? rsp1_data : rsp0_data},
                        {32'b0, q_data[0]});
                    void'(q_port.pop_front());
                    void'(q_data.pop_front());
                end
                n_done++;
            end
            tick();
        end
        chk("alt_done", 64'(n_done), 64'd8);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset during WAIT on a requester-0 op
        req0_valid = 1'b1; req0_op = 3'd0; req0_rs1 = $urandom; req0_rs2 = $urandom;
        g = 0;
        for (int w = 0; w < 20 && g == 0; w++) begin
            #1;
            if (req0_ready) g = 1;
            tick();
        end
        chk("abort_accept", 64'(g), 64'd1);
        req0_valid = 1'b0;
        tick(); tick(); tick();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd3;
        #1;
        chk("idle_after_reset", {63'b0, req1_ready}, 64'd1);
        req1_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("no_rsp_after_abort", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("ptr_reset", {62'b0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        do_op(0, 3'd4, 32'hFEDCBA98, 32'h76543210, 0, acc, rel);
        do_op(1, 3'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, acc, rel);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
